alarm_scheduler: RTL and testbench

Multi-slot alarm controller that sits beside the time-of-day counter. It holds NUM_SLOTS programmable alarm times and compares them with the running hh:mm:ss on each second tick. It queues simultaneous matches and sequences the alarm output through ring, snooze and dismiss. The single-slot set_alarm/alarm_hh/mm/ss interface of the clock core is superseded by this block.

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/alarm_scheduler_if.sv | 47 ++++
 rtl/alarm_slot.sv | 55 +++++
 rtl/alarm_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_pkg                                                    |
// | Description : Shared types and constants for the alarm scheduler: FSM      |
// |               state encoding, hh:mm:ss time struct, range limits and a     |
// |               helper that validates a time value.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alarm_pkg;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] MAX_HH = 6'd23;
    localparam logic [TIME_W-1:0] MAX_MM = 6'd59;
    localparam logic [TIME_W-1:0] MAX_SS = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hh;
        logic [TIME_W-1:0] mm;
        logic [TIME_W-1:0] ss;
    } alarm_time_t;

    // True when every field lies inside its legal clock range.
    function automatic logic time_valid(input alarm_time_t t);
        return (t.hh <= MAX_HH) && (t.mm <= MAX_MM) && (t.ss <= MAX_SS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_scheduler_if                                           |
// | Description : Bus bundle between the alarm scheduler and its host.         |
// |               master : drives time/tick, slot writes, snooze/dismiss       |
// |               slave  : the scheduler; returns alarm, active_slot and the   |
// |                        armed/pending masks                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alarm_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                 sec_tick;
    logic [5:0]           current_hh;
    logic [5:0]           current_mm;
    logic [5:0]           current_ss;
    logic                 wr_en;
    logic [SLOT_W-1:0]    wr_slot;
    logic [5:0]           wr_hh;
    logic [5:0]           wr_mm;
    logic [5:0]           wr_ss;
    logic                 wr_arm;
    logic                 snooze;
    logic                 dismiss;
    logic                 alarm;
    logic [SLOT_W-1:0]    active_slot;
    logic [NUM_SLOTS-1:0] armed_mask;
    logic [NUM_SLOTS-1:0] pending_mask;

    modport master (
        output sec_tick, current_hh, current_mm, current_ss,
        output wr_en, wr_slot, wr_hh, wr_mm, wr_ss, wr_arm,
        output snooze, dismiss,
        input  alarm, active_slot, armed_mask, pending_mask
    );

    modport slave (
        input  sec_tick, current_hh, current_mm, current_ss,
        input  wr_en, wr_slot, wr_hh, wr_mm, wr_ss, wr_arm,
        input  snooze, dismiss,
        output alarm, active_slot, armed_mask, pending_mask
    );

endinterface
`default_nettype wire

// File: rtl/alarm_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_slot                                                   |
// | Description : One alarm slot: stored time plus armed flag. Writes with an  |
// |               out-of-range field are dropped. o_match is combinational     |
// |               (armed and stored time equals current time).                 |
// | Ports       : clk, rst         - clock, synchronous active-high reset      |
// |               i_wr_en          - write strobe already decoded to this slot |
// |               i_wr_time/i_wr_arm - value to store                          |
// |               i_clr_arm        - drop the armed flag (one-shot support)    |
// |               i_cur_time       - running time of day                       |
// |               o_match/o_armed  - match indication and armed flag           |
// |               o_wr_ok          - write was accepted this cycle             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alarm_slot
    import alarm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  alarm_time_t i_wr_time,
    input  logic        i_wr_arm,
    input  logic        i_clr_arm,
    input  alarm_time_t i_cur_time,
    output logic        o_match,
    output logic        o_armed,
    output logic        o_wr_ok
);

    alarm_time_t r_time;
    logic        r_armed;
    logic        w_wr_ok;

    assign w_wr_ok = i_wr_en && time_valid(i_wr_time);

    // A write beats an auto-disarm in the same cycle: the host's intent wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_time  <= '0;
            r_armed <= 1'b0;
        end else if (w_wr_ok) begin
            r_time  <= i_wr_time;
            r_armed <= i_wr_arm;
        end else if (i_clr_arm) begin
            r_armed <= 1'b0;
        end
    end

    assign o_match = r_armed && (r_time == i_cur_time);
    assign o_armed = r_armed;
    assign o_wr_ok = w_wr_ok;

endmodule
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_scheduler                                              |
// | Description : Multi-slot alarm controller. Compares NUM_SLOTS alarm times  |
// |               against the running time on each sec_tick, queues matches    |
// |               in pending_mask and sequences ring / snooze / dismiss.       |
// | Ports       : clk, reset - clock, synchronous active-high reset            |
// |               bus        - alarm_scheduler_if.slave (time, writes,         |
// |                            snooze/dismiss in; alarm, active_slot,          |
// |                            armed_mask, pending_mask out)                   |
// | Options     : ALARM_SCHED_ONESHOT_EN - disarm a slot when it starts ringing|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic               clk,
    input  logic               reset,
    alarm_scheduler_if.slave   bus
);

    localparam int c_SLOT_W   = $clog2(NUM_SLOTS);
    localparam int c_RING_W   = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
    localparam int c_SNOOZE_W = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam logic [c_RING_W-1:0]   c_RING_LAST   = c_RING_W'(RING_SECS - 1);
    localparam logic [c_SNOOZE_W-1:0] c_SNOOZE_LAST = c_SNOOZE_W'(SNOOZE_SECS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_alarm;
    logic                  w_alarm_nxt;
    logic [c_SLOT_W-1:0]   r_active;
    logic [c_SLOT_W-1:0]   w_active_nxt;
    logic [c_RING_W-1:0]   r_ring_cnt;
    logic [c_RING_W-1:0]   w_ring_cnt_nxt;
    logic [c_SNOOZE_W-1:0] r_snooze_cnt;
    logic [c_SNOOZE_W-1:0] w_snooze_cnt_nxt;
    logic [NUM_SLOTS-1:0]  r_pending;
    logic [NUM_SLOTS-1:0]  w_pending_nxt;

    alarm_time_t           w_cur_time;
    alarm_time_t           w_wr_time;
    logic [NUM_SLOTS-1:0]  w_wr_sel;
    logic [NUM_SLOTS-1:0]  w_wr_ok;
    logic [NUM_SLOTS-1:0]  w_match;
    logic [NUM_SLOTS-1:0]  w_armed;
    logic [NUM_SLOTS-1:0]  w_clr_arm;
    logic [NUM_SLOTS-1:0]  w_sel_onehot;
    logic [c_SLOT_W-1:0]   w_sel_idx;
    logic                  w_select;
    logic                  w_cancel;

    assign w_cur_time = {bus.current_hh, bus.current_mm, bus.current_ss};
    assign w_wr_time  = {bus.wr_hh, bus.wr_mm, bus.wr_ss};

    // ------------------------------------------------------------------
    // Slot array
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign w_wr_sel[i] = bus.wr_en && (bus.wr_slot == c_SLOT_W'(i));

        alarm_slot u_slot (
            .clk        (clk),
            .rst        (reset),
            .i_wr_en    (w_wr_sel[i]),
            .i_wr_time  (w_wr_time),
            .i_wr_arm   (bus.wr_arm),
            .i_clr_arm  (w_clr_arm[i]),
            .i_cur_time (w_cur_time),
            .o_match    (w_match[i]),
            .o_armed    (w_armed[i]),
            .o_wr_ok    (w_wr_ok[i])
        );
    end

    // ------------------------------------------------------------------
    // Lowest-index pending slot wins (scan high to low, last hit sticks)
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx       = c_SLOT_W'(i);
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_select = (r_state == IDLE) && (|r_pending);

`ifdef ALARM_SCHED_ONESHOT_EN
    assign w_clr_arm = w_select ? w_sel_onehot : '0;
`else
    assign w_clr_arm = '0;
`endif

    // Only a disarming write to the slot being serviced stops the alarm;
    // re-programming it while armed lets the current ring continue.
    assign w_cancel = w_wr_ok[r_active] && !bus.wr_arm;

    // Matches are gated to the tick; an accepted write overrides both a
    // same-cycle match and any older queued match for that slot.
    assign w_pending_nxt = ((r_pending & ~(w_select ? w_sel_onehot : '0))
                            | (bus.sec_tick ? w_match : '0))
                           & ~w_wr_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = RING;
                end
            end
            RING: begin
                if (bus.dismiss || w_cancel) begin
                    w_state_nxt = IDLE;
                end else if (bus.sec_tick && (r_ring_cnt == c_RING_LAST)) begin
                    w_state_nxt = IDLE;
                end else if (bus.snooze) begin
                    w_state_nxt = SNOOZE;
                end
            end
            SNOOZE: begin
                if (bus.dismiss || w_cancel) begin
                    w_state_nxt = IDLE;
                end else if (bus.sec_tick && (r_snooze_cnt == c_SNOOZE_LAST)) begin
                    w_state_nxt = RING;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and counters
    // ------------------------------------------------------------------
    always_comb begin
        w_alarm_nxt      = (w_state_nxt == RING);
        w_active_nxt     = w_select ? w_sel_idx : r_active;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;

        // Counters restart on state entry and saturate at their last value.
        if ((r_state != RING) && (w_state_nxt == RING)) begin
            w_ring_cnt_nxt = '0;
        end else if ((r_state == RING) && bus.sec_tick && (r_ring_cnt != c_RING_LAST)) begin
            w_ring_cnt_nxt = r_ring_cnt + 1'b1;
        end

        if ((r_state != SNOOZE) && (w_state_nxt == SNOOZE)) begin
            w_snooze_cnt_nxt = '0;
        end else if ((r_state == SNOOZE) && bus.sec_tick && (r_snooze_cnt != c_SNOOZE_LAST)) begin
            w_snooze_cnt_nxt = r_snooze_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm      <= 1'b0;
            r_active     <= '0;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_pending    <= '0;
        end else begin
            r_alarm      <= w_alarm_nxt;
            r_active     <= w_active_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_pending    <= w_pending_nxt;
        end
    end

    assign bus.alarm        = r_alarm;
    assign bus.active_slot  = r_active;
    assign bus.armed_mask   = w_armed;
    assign bus.pending_mask = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alarm_scheduler                                           |
// | Description : Directed self-checking bench for alarm_scheduler with        |
// |               NUM_SLOTS=4, RING_SECS=3, SNOOZE_SECS=2.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alarm_scheduler;
    import alarm_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    alarm_scheduler_if #(.NUM_SLOTS(4)) bus ();

    alarm_scheduler #(
        .NUM_SLOTS   (4),
        .RING_SECS   (3),
        .SNOOZE_SECS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land just after the edge so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [5:0] hh, input logic [5:0] mm, input logic [5:0] ss);
        bus.current_hh = hh;
        bus.current_mm = mm;
        bus.current_ss = ss;
        bus.sec_tick   = 1'b1;
        step();
        bus.sec_tick   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] slot, input logic [5:0] hh, input logic [5:0] mm,
                      input logic [5:0] ss, input logic arm);
        bus.wr_slot = slot;
        bus.wr_hh   = hh;
        bus.wr_mm   = mm;
        bus.wr_ss   = ss;
        bus.wr_arm  = arm;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_dismiss();
        bus.dismiss = 1'b1;
        step();
        bus.dismiss = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_armed;
        n_checks = 0;
        n_fails  = 0;
        bus.sec_tick = 1'b0; bus.current_hh = '0; bus.current_mm = '0; bus.current_ss = '0;
        bus.wr_en = 1'b0; bus.wr_slot = '0; bus.wr_hh = '0; bus.wr_mm = '0; bus.wr_ss = '0;
        bus.wr_arm = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_alarm",   {31'd0, bus.alarm},        32'd0);
        chk("rst_armed",   {28'd0, bus.armed_mask},   32'd0);
        chk("rst_pending", {28'd0, bus.pending_mask}, 32'd0);
        chk("rst_active",  {30'd0, bus.active_slot},  32'd0);
        chk("rst_state",   {30'd0, dut.r_state},      {30'd0, IDLE});

        // Single alarm, timeout after three ring ticks
        wr(2'd0, 6'd0, 6'd0, 6'd5, 1'b1);
        chk("t1_armed", {28'd0, bus.armed_mask}, 32'h1);
        for (int s = 1; s < 5; s++) begin
            tick(6'd0, 6'd0, 6'(s));
            step();
        end
        chk("t1_pre_alarm", {31'd0, bus.alarm}, 32'd0);
        tick(6'd0, 6'd0, 6'd5);
        chk("t1_pend",    {28'd0, bus.pending_mask}, 32'h1);
        chk("t1_alarm_t1", {31'd0, bus.alarm},       32'd0);
        step();
        chk("t1_alarm_t2", {31'd0, bus.alarm},       32'd1);
        chk("t1_active",   {30'd0, bus.active_slot}, 32'd0);
        chk("t1_pend_clr", {28'd0, bus.pending_mask}, 32'h0);
`ifdef ALARM_SCHED_ONESHOT_EN
        chk("t1_oneshot_armed", {31'd0, bus.armed_mask[0]}, 32'd0);
`else
        chk("t1_rearm_armed",   {31'd0, bus.armed_mask[0]}, 32'd1);
`endif
        tick(6'd1, 6'd0, 6'd0);
        step();
        tick(6'd1, 6'd0, 6'd1);
        chk("t1_ring_2tick", {31'd0, bus.alarm}, 32'd1);
        step();
        tick(6'd1, 6'd0, 6'd2);
        chk("t1_timeout",       {31'd0, bus.alarm}, 32'd0);
        chk("t1_timeout_state", {30'd0, dut.r_state}, {30'd0, IDLE});

        // Two simultaneous matches: lowest index first, next one after dismiss
        wr(2'd1, 6'd0, 6'd0, 6'd7, 1'b1);
        wr(2'd2, 6'd0, 6'd0, 6'd7, 1'b1);
        tick(6'd0, 6'd0, 6'd7);
        chk("t2_pend_both", {28'd0, bus.pending_mask}, 32'h6);
        step();
        chk("t2_alarm",  {31'd0, bus.alarm},        32'd1);
        chk("t2_active", {30'd0, bus.active_slot},  32'd1);
        chk("t2_pend",   {28'd0, bus.pending_mask}, 32'h4);
        pulse_dismiss();
        chk("t2_dismiss", {31'd0, bus.alarm}, 32'd0);
        step();
        chk("t2_next_alarm",  {31'd0, bus.alarm},       32'd1);
        chk("t2_next_active", {30'd0, bus.active_slot}, 32'd2);
        pulse_dismiss();
        chk("t2_done", {31'd0, bus.alarm}, 32'd0);

        // Snooze, re-ring, then dismiss+snooze together
        wr(2'd0, 6'd0, 6'd0, 6'd5, 1'b1);
        tick(6'd0, 6'd0, 6'd5);
        step();
        chk("t3_ring", {31'd0, bus.alarm}, 32'd1);
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        chk("t3_snoozed", {31'd0, bus.alarm}, 32'd0);
        tick(6'd1, 6'd0, 6'd3);
        chk("t3_snz_1tick", {31'd0, bus.alarm}, 32'd0);
        step();
        tick(6'd1, 6'd0, 6'd4);
        chk("t3_rering",        {31'd0, bus.alarm},       32'd1);
        chk("t3_rering_active", {30'd0, bus.active_slot}, 32'd0);
        bus.snooze  = 1'b1;
        bus.dismiss = 1'b1;
        step();
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
        chk("t3_both_alarm", {31'd0, bus.alarm},   32'd0);
        chk("t3_both_state", {30'd0, dut.r_state}, {30'd0, IDLE});

        // Invalid writes are dropped; disarming write cancels a ring
`ifdef ALARM_SCHED_ONESHOT_EN
        exp_armed = 4'b0000;
`else
        exp_armed = 4'b0111;
`endif
        wr(2'd3, 6'd24, 6'd0, 6'd0, 1'b1);
        chk("t4_bad_hh", {28'd0, bus.armed_mask}, {28'd0, exp_armed});
        wr(2'd3, 6'd0, 6'd60, 6'd0, 1'b1);
        chk("t4_bad_mm", {28'd0, bus.armed_mask}, {28'd0, exp_armed});
        wr(2'd3, 6'd0, 6'd0, 6'd60, 1'b1);
        chk("t4_bad_ss", {28'd0, bus.armed_mask}, {28'd0, exp_armed});
        wr(2'd0, 6'd0, 6'd0, 6'd5, 1'b1);
        tick(6'd0, 6'd0, 6'd5);
        step();
        chk("t4_ring", {31'd0, bus.alarm}, 32'd1);
        wr(2'd0, 6'd0, 6'd0, 6'd9, 1'b1);
        chk("t4_rearm_keeps_ring", {31'd0, bus.alarm}, 32'd1);
        wr(2'd0, 6'd0, 6'd0, 6'd9, 1'b0);
        chk("t4_cancel",       {31'd0, bus.alarm},         32'd0);
        chk("t4_cancel_armed", {31'd0, bus.armed_mask[0]}, 32'd0);

        // Reset in the middle of a ring
        wr(2'd0, 6'd0, 6'd0, 6'd5, 1'b1);
        tick(6'd0, 6'd0, 6'd5);
        step();
        chk("t5_ring", {31'd0, bus.alarm}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_alarm",   {31'd0, bus.alarm},        32'd0);
        chk("t5_rst_armed",   {28'd0, bus.armed_mask},   32'd0);
        chk("t5_rst_pending", {28'd0, bus.pending_mask}, 32'd0);
        tick(6'd0, 6'd0, 6'd5);
        chk("t5_old_pend", {28'd0, bus.pending_mask}, 32'd0);
        step();
        chk("t5_old_alarm", {31'd0, bus.alarm}, 32'd0);

        // Write coinciding with a match of the old value wins
        wr(2'd1, 6'd0, 6'd0, 6'd7, 1'b1);
        bus.wr_slot = 2'd1; bus.wr_hh = 6'd0; bus.wr_mm = 6'd0; bus.wr_ss = 6'd8;
        bus.wr_arm  = 1'b1; bus.wr_en = 1'b1;
        tick(6'd0, 6'd0, 6'd7);
        bus.wr_en = 1'b0;
        chk("t6_wr_wins", {28'd0, bus.pending_mask}, 32'd0);
        step();
        chk("t6_no_alarm", {31'd0, bus.alarm}, 32'd0);
        tick(6'd0, 6'd0, 6'd8);
        chk("t6_new_pend", {28'd0, bus.pending_mask}, 32'h2);
        step();
        chk("t6_new_alarm",  {31'd0, bus.alarm},       32'd1);
        chk("t6_new_active", {30'd0, bus.active_slot}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
